// File: rtl/rs15_13_decoder_pkg.sv
// rs15_13_decoder_pkg
// Shared GF(16) / RS(15,13) definitions for the receive-side decoder.
// Contents:
//   SYMBOL_WIDTH, N, K      - code geometry
//   PRIM_POLY               - primitive polynomial x^4+x+1
//   FCR, ROOT1, ROOT2       - generator roots alpha^1, alpha^2
//   state_t                 - decoder FSM states
//   mulAlpha                - multiply a symbol by alpha
//   sym2idx / idx2sym       - log / antilog tables (index 0 = zero, i = alpha^(i-1))
//   mod15                   - fold a 5-bit exponent sum back into 0..14
// Symbol bit order is reversed with respect to the usual polynomial form:
// bit3 carries the alpha^0 coefficient and bit0 the alpha^3 coefficient.
package rs15_13_decoder_pkg;

  localparam int SYMBOL_WIDTH = 4;
  localparam int N            = 15;
  localparam int K            = 13;

  localparam logic [4:0] PRIM_POLY = 5'b10011;

  localparam int FCR   = 1;
  localparam int ROOT1 = FCR;
  localparam int ROOT2 = FCR + 1;

  localparam logic [3:0] LAST_IN  = 4'(N - 1);
  localparam logic [3:0] LAST_OUT = 4'(K - 1);

  typedef logic [SYMBOL_WIDTH-1:0] symbol_t;

  typedef enum logic [1:0] {
    COLLECT,
    SOLVE,
    OUTPUT
  } state_t;

  // Flip into conventional (bit0 = alpha^0) order, shift, reduce, flip back.
  function automatic symbol_t mulAlpha(input symbol_t s);
    logic [3:0] std;
    std = {s[0], s[1], s[2], s[3]};
    std = {std[2:0], 1'b0} ^ (std[3] ? PRIM_POLY[3:0] : 4'b0000);
    return {std[0], std[1], std[2], std[3]};
  endfunction

  function automatic logic [3:0] sym2idx(input symbol_t s);
    case (s)
      4'b1000: return 4'd1;
      4'b0100: return 4'd2;
      4'b0010: return 4'd3;
      4'b0001: return 4'd4;
      4'b1100: return 4'd5;
      4'b0110: return 4'd6;
      4'b0011: return 4'd7;
      4'b1101: return 4'd8;
      4'b1010: return 4'd9;
      4'b0101: return 4'd10;
      4'b1110: return 4'd11;
      4'b0111: return 4'd12;
      4'b1111: return 4'd13;
      4'b1011: return 4'd14;
      4'b1001: return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  function automatic symbol_t idx2sym(input logic [3:0] idx);
    case (idx)
      4'd1:    return 4'b1000;
      4'd2:    return 4'b0100;
      4'd3:    return 4'b0010;
      4'd4:    return 4'b0001;
      4'd5:    return 4'b1100;
      4'd6:    return 4'b0110;
      4'd7:    return 4'b0011;
      4'd8:    return 4'b1101;
      4'd9:    return 4'b1010;
      4'd10:   return 4'b0101;
      4'd11:   return 4'b1110;
      4'd12:   return 4'b0111;
      4'd13:   return 4'b1111;
      4'd14:   return 4'b1011;
      4'd15:   return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  // Inputs never exceed 29, so a single conditional subtract is enough.
  function automatic logic [3:0] mod15(input logic [4:0] v);
    if (v >= 5'd15) return 4'(v - 5'd15);
    else            return v[3:0];
  endfunction

endpackage

// File: rtl/gf16_mul_alpha_const.sv
// gf16_mul_alpha_const
// Constant multiply of a GF(16) symbol by alpha^C. With C fixed at
// elaboration the repeated alpha steps collapse into a small XOR network.
// Ports:
//   i_sym - input symbol
//   o_sym - i_sym * alpha^C
module gf16_mul_alpha_const
  import rs15_13_decoder_pkg::*;
#(
  parameter int C = 1
) (
  input  logic [SYMBOL_WIDTH-1:0] i_sym,
  output logic [SYMBOL_WIDTH-1:0] o_sym
);

  symbol_t w_acc;

  always_comb begin
    w_acc = i_sym;
    for (int n = 0; n < C; n++) begin
      w_acc = mulAlpha(w_acc);
    end
  end

  assign o_sym = w_acc;

endmodule

// File: rtl/rs15_13_decoder.sv
// rs15_13_decoder
// Streaming RS(15,13) decoder over GF(16). Collects one 15-symbol codeword
// (x^14 coefficient first), evaluates S1 = r(alpha) and S2 = r(alpha^2) by
// Horner's rule while the symbols arrive, spends one cycle solving for a
// single error location/value, then streams the 13 data symbols out with
// the error patched in.
// Ports:
//   i_clk, i_rst_n          - clock, asynchronous active-low reset
//   i_in_valid/o_in_ready   - input handshake, i_in_symbol received symbol
//   o_out_valid/i_out_ready - output handshake, o_out_symbol data symbol
//   o_out_last              - marks the 13th data symbol
//   o_out_corrected         - one symbol error was corrected in this frame
//   o_out_uncorrectable     - error seen that cannot be corrected
module rs15_13_decoder
  import rs15_13_decoder_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [SYMBOL_WIDTH-1:0] i_in_symbol,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [SYMBOL_WIDTH-1:0] o_out_symbol,
  output logic                    o_out_last,
  output logic                    o_out_corrected,
  output logic                    o_out_uncorrectable
);

  state_t  r_state;
  state_t  w_next_state;

  // Shared counter: input position k during COLLECT, output index during OUTPUT.
  logic [3:0] r_count;
  symbol_t    r_buf [0:K-1];
  symbol_t    r_s1;
  symbol_t    r_s2;
  logic       r_corr;
  logic       r_uncorr;
  logic [3:0] r_kc;
  symbol_t    r_err;

  symbol_t    w_s1_alpha;
  symbol_t    w_s2_alpha2;
  logic       w_accept;
  logic       w_fix;

  logic [4:0] w_log1;
  logic [4:0] w_log2;
  logic [3:0] w_j;
  logic [3:0] w_dbl;
  logic [3:0] w_eexp;
  logic [3:0] w_kc;
  symbol_t    w_err;

  gf16_mul_alpha_const #(.C(ROOT1)) u_mul_s1 (
    .i_sym (r_s1),
    .o_sym (w_s1_alpha)
  );

  gf16_mul_alpha_const #(.C(ROOT2)) u_mul_s2 (
    .i_sym (r_s2),
    .o_sym (w_s2_alpha2)
  );

  assign w_accept = (r_state == COLLECT) && i_in_valid;

  // Exponents live in 0..14; they are only meaningful when the syndrome is
  // nonzero, which SOLVE checks before using them.
  assign w_log1 = {1'b0, sym2idx(r_s1)} - 5'd1;
  assign w_log2 = {1'b0, sym2idx(r_s2)} - 5'd1;

  // Single error e at degree d gives S1 = e*a^d, S2 = e*a^2d, so
  // d = log S2 - log S1 and e = S1^2 / S2.
  assign w_j    = mod15(w_log2 + 5'd15 - w_log1);
  assign w_dbl  = mod15(w_log1 + w_log1);
  assign w_eexp = mod15({1'b0, w_dbl} + 5'd15 - w_log2);
  assign w_err  = idx2sym(w_eexp + 4'd1);
  assign w_kc   = LAST_IN - w_j;

  // Parity positions (13, 14) can never match the output index, so a parity
  // error leaves the data untouched.
  assign w_fix = r_corr && (r_count == r_kc);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= COLLECT;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    o_out_last   = 1'b0;
    o_out_symbol = '0;
    case (r_state)
      COLLECT: begin
        o_in_ready = 1'b1;
        if (i_in_valid && (r_count == LAST_IN)) w_next_state = SOLVE;
      end
      SOLVE: begin
        w_next_state = OUTPUT;
      end
      OUTPUT: begin
        o_out_valid  = 1'b1;
        o_out_last   = (r_count == LAST_OUT);
        o_out_symbol = r_buf[r_count] ^ (w_fix ? r_err : 4'b0000);
        if (i_out_ready && (r_count == LAST_OUT)) w_next_state = COLLECT;
      end
      default: begin
        w_next_state = COLLECT;
      end
    endcase
  end

  // Counter, syndromes and solver results. The counter wraps to 0 on the
  // 15th symbol so it is already the output index when OUTPUT starts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count  <= '0;
      r_s1     <= '0;
      r_s2     <= '0;
      r_corr   <= 1'b0;
      r_uncorr <= 1'b0;
      r_kc     <= '0;
      r_err    <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (i_in_valid) begin
            r_s1    <= w_s1_alpha ^ i_in_symbol;
            r_s2    <= w_s2_alpha2 ^ i_in_symbol;
            r_count <= (r_count == LAST_IN) ? 4'd0 : r_count + 4'd1;
          end
        end
        SOLVE: begin
          if ((r_s1 != '0) && (r_s2 != '0)) begin
            r_corr <= 1'b1;
            r_kc   <= w_kc;
            r_err  <= w_err;
          end else if ((r_s1 != '0) || (r_s2 != '0)) begin
            r_uncorr <= 1'b1;
          end
        end
        OUTPUT: begin
          if (i_out_ready) begin
            if (r_count == LAST_OUT) begin
              r_count  <= '0;
              r_s1     <= '0;
              r_s2     <= '0;
              r_corr   <= 1'b0;
              r_uncorr <= 1'b0;
            end else begin
              r_count <= r_count + 4'd1;
            end
          end
        end
        default: begin
          r_count <= '0;
        end
      endcase
    end
  end

  // Only the data positions are kept; parity symbols feed the syndromes only.
  always_ff @(posedge i_clk) begin
    if (w_accept && (r_count < 4'(K))) r_buf[r_count] <= i_in_symbol;
  end

  assign o_out_corrected     = r_corr;
  assign o_out_uncorrectable = r_uncorr;

endmodule
